// File: rtl/picture_scanout_if.sv
// Pixel stream bundle between the scanout engine and its sink.
// Ports: pix_data/pix_valid/pix_sof/pix_eol/pix_eof from master, pix_ready from slave.
interface picture_scanout_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport master (
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/picture_scanout.sv
// Frame readout: sweeps the image through the memory picture port and emits pixels.
// Ports: clk, rst, start, continuous, picture_radrs/picture_data, pix (stream), busy, frame_done.
module picture_scanout #(
  parameter int          IMG_WIDTH  = 32,
  parameter int          IMG_HEIGHT = 32,
  parameter logic [10:0] BASE_ADRS  = 11'd1024,
  parameter int          RD_LATENCY = 1,
  parameter int          BUF_DEPTH  = RD_LATENCY + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  output logic [10:0] picture_radrs,
  input  logic [23:0] picture_data,
  picture_scanout_if.master pix,
  output logic        busy,
  output logic        frame_done
);
  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } mark_t;

  typedef struct packed {
    logic  vld;
    mark_t mk;
  } tag_t;

  typedef struct packed {
    mark_t       mk;
    logic [23:0] data;
  } ent_t;

  state_t          state;
  state_t          state_nx;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  tag_t            tag [RD_LATENCY];
  ent_t            fifo [BUF_DEPTH];
  ent_t            head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   infl;
  logic            issue;
  logic            x_last;
  logic            y_last;
  logic            frame_last;
  logic            push;
  logic            pop;
  logic            eof_xfer;
  logic            rewind;
  mark_t           mk_now;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign x_last     = (x == XW'(IMG_WIDTH - 1));
  assign y_last     = (y == YW'(IMG_HEIGHT - 1));
  // Credits cover both reads still in flight and entries waiting in the buffer.
  assign issue      = (state == SCAN) && ((occ + infl) < CW'(BUF_DEPTH));
  assign frame_last = issue && x_last && y_last;
  assign rewind     = (state == IDLE) || (state == DONE);

  assign mk_now.sof = (x == '0) && (y == '0);
  assign mk_now.eol = x_last;
  assign mk_now.eof = x_last && y_last;

  assign push     = tag[RD_LATENCY-1].vld;
  assign pop      = pix.pix_valid && pix.pix_ready;
  assign head     = fifo[rd_ptr];
  assign eof_xfer = pop && head.mk.eof;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (frame_last) state_nx = DRAIN;
      DRAIN:   if (eof_xfer) state_nx = DONE;
      DONE:    state_nx = continuous ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == SCAN) || (state == DRAIN);
    frame_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || rewind) begin
      picture_radrs <= BASE_ADRS;
      x             <= '0;
      y             <= '0;
    end else if (issue) begin
      picture_radrs <= picture_radrs + 11'd1;
      if (x_last) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) tag[i] <= '0;
      infl <= '0;
    end else begin
      tag[0] <= {issue, mk_now};
      for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
      infl <= infl + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) fifo[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {tag[RD_LATENCY-1].mk, picture_data};
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  assign pix.pix_valid = (occ != '0);
  assign pix.pix_data  = pix.pix_valid ? head.data : '0;
  assign pix.pix_sof   = pix.pix_valid && head.mk.sof;
  assign pix.pix_eol   = pix.pix_valid && head.mk.eol;
  assign pix.pix_eof   = pix.pix_valid && head.mk.eof;
endmodule

// File: tb/tb_picture_scanout.sv
// Bench for picture_scanout: frame model scoreboard plus directed scenarios.
// Two instances: default geometry, and a 4x4 frame that wraps the address space.
module tb_picture_scanout;
  localparam int          W     = 32;
  localparam int          H     = 32;
  localparam int          N     = W * H;
  localparam int          LAT   = 1;
  localparam logic [10:0] BASE  = 11'd1024;
  localparam logic [10:0] BASE1 = 11'd2040;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        start1 = 1'b0;
  logic        cont   = 1'b0;
  logic [10:0] radrs0;
  logic [10:0] radrs1;
  logic [23:0] rdata0 = '0;
  logic [23:0] rdata1 = '0;
  logic        busy0;
  logic        busy1;
  logic        done0;
  logic        done1;

  picture_scanout_if p0();
  picture_scanout_if p1();

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [23:0] pat(input logic [10:0] a);
    return {2'b10, a, ~a};
  endfunction

  // Memory picture port: data follows the address by one cycle.
  always @(posedge clk) begin
    rdata0 <= pat(radrs0);
    rdata1 <= pat(radrs1);
  end

  picture_scanout #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .BASE_ADRS(BASE), .RD_LATENCY(LAT)
  ) u0 (
    .clk(clk), .rst(rst), .start(start), .continuous(cont),
    .picture_radrs(radrs0), .picture_data(rdata0), .pix(p0),
    .busy(busy0), .frame_done(done0)
  );

  picture_scanout #(
    .IMG_WIDTH(4), .IMG_HEIGHT(4), .BASE_ADRS(BASE1), .RD_LATENCY(LAT)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .continuous(1'b0),
    .picture_radrs(radrs1), .picture_data(rdata1), .pix(p1),
    .busy(busy1), .frame_done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state for u0: index of the next pixel the frame must deliver.
  int          k       = 0;
  int          fx      = 0;
  int          dones   = 0;
  int          sof_cyc = -1;
  int          eof_cyc = -1;
  logic [23:0] first_data = '0;
  logic        stall   = 1'b0;
  logic [27:0] held    = '0;

  always @(negedge clk) begin
    if (rst) begin
      k     = 0;
      fx    = 0;
      stall = 1'b0;
    end else begin
      if (stall)
        chk("hold", {p0.pix_sof, p0.pix_eol, p0.pix_eof, p0.pix_data, p0.pix_valid},
            {held[27:1], 1'b1});
      if (p0.pix_valid && p0.pix_ready) begin
        chk("pix_data", p0.pix_data, pat(BASE + 11'(k)));
        chk("flags", {p0.pix_sof, p0.pix_eol, p0.pix_eof},
            {(k == 0), ((k % W) == W - 1), (k == N - 1)});
        if (k == 0) begin
          sof_cyc    = cyc_n;
          first_data = p0.pix_data;
        end
        if (k == N - 1) eof_cyc = cyc_n;
        k = (k == N - 1) ? 0 : k + 1;
        fx++;
      end
      if (done0) begin
        dones++;
        chk("done_count", fx, N);
        chk("done_busy", busy0, 0);
        fx = 0;
      end
      stall = p0.pix_valid && !p0.pix_ready;
      held  = {p0.pix_sof, p0.pix_eol, p0.pix_eof, p0.pix_data, 1'b1};
    end
  end

  int          n1     = 0;
  int          dones1 = 0;
  logic [23:0] d1 [16];
  logic [2:0]  f1 [16];

  always @(negedge clk) begin
    if (!rst) begin
      if (p1.pix_valid && p1.pix_ready && n1 < 16) begin
        d1[n1] = p1.pix_data;
        f1[n1] = {p1.pix_sof, p1.pix_eol, p1.pix_eof};
        n1++;
      end
      if (done1) dones1++;
    end
  end

  task automatic wait_done(input string nm, input int budget);
    int d0;
    int t;
    d0 = dones;
    t  = 0;
    while (dones == d0 && t < budget) begin
      tick();
      t++;
    end
    chk(nm, dones - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int t;
    int d;
    int e1;
    p0.pix_ready = 1'b1;
    p1.pix_ready = 1'b1;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_radrs", radrs0, 11'd1024);
    chk("reset_valid", p0.pix_valid, 0);
    chk("reset_data", p0.pix_data, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("scan_busy", busy0, 1);
    d = dones;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("abort_radrs", radrs0, 11'd1024);
    chk("abort_valid", p0.pix_valid, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_idle_valid", p0.pix_valid, 0);
    end
    chk("abort_no_done", dones - d, 0);

    tick();
    s = cyc_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("single_done", 3000);
    chk("first_latency", sof_cyc - s, 3);
    chk("first_pix_lit", first_data, 24'hA003FF);
    chk("no_bubbles", eof_cyc - sof_cyc, N - 1);
    tick();
    chk("single_idle_busy", busy0, 0);

    p0.pix_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!p0.pix_valid && t < 20) begin
      tick();
      t++;
    end
    chk("bp_first_valid", p0.pix_valid, 1);
    repeat (10) tick();
    chk("bp_radrs_mid", radrs0, 11'd1027);
    repeat (10) tick();
    chk("bp_radrs_end", radrs0, 11'd1027);
    chk("bp_busy", busy0, 1);
    d = dones;
    t = 0;
    while (dones == d && t < 10000) begin
      p0.pix_ready = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    chk("bp_frame_done", dones - d, 1);
    p0.pix_ready = 1'b1;
    repeat (3) tick();

    d = dones;
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("cont_done1", 3000);
    e1 = eof_cyc;
    cont = 1'b0;
    wait_done("cont_done2", 3000);
    chk("cont_gap", sof_cyc - e1, 4);
    repeat (10) tick();
    chk("cont_two_dones", dones - d, 2);
    chk("cont_idle", busy0, 0);

    d = dones;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (fx < 100 && t < 500) begin
      tick();
      t++;
    end
    chk("busy_at_100", busy0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("restart_done", 3000);
    repeat (50) tick();
    chk("restart_one_done", dones - d, 1);
    chk("restart_idle_busy", busy0, 0);
    chk("restart_idle_valid", p0.pix_valid, 0);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    t = 0;
    while (dones1 == 0 && t < 200) begin
      tick();
      t++;
    end
    chk("wrap_done", dones1, 1);
    chk("wrap_count", n1, 16);
    for (int i = 0; i < 16; i++) begin
      chk("wrap_data", d1[i], pat(BASE1 + 11'(i)));
      chk("wrap_flags", f1[i], {(i == 0), ((i % 4) == 3), (i == 15)});
    end
    chk("wrap_lit0", d1[0], 24'hBFC007);
    chk("wrap_lit8", d1[8], 24'h8007FF);
    chk("wrap_lit15", d1[15], 24'h803FF8);
    chk("wrap_eol3", f1[3], 3'b010);
    chk("wrap_eof15", f1[15], 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/picture_scanout.md
Name: picture_scanout

Overview:
- Frame-readout engine on the picture port of the shared memory; sits directly downstream of the memory's picture_radrs/picture_data interface.
- Sweeps an IMG_WIDTH x IMG_HEIGHT image stored linearly from BASE_ADRS and issues one read per pixel.
- Absorbs the fixed, non-stallable read latency in a credit-limited skid buffer.
- Emits a valid/ready 24-bit pixel stream with start-of-frame, end-of-line and end-of-frame markers, for a display or capture sink.

Parameters:
IMG_WIDTH, 32, pixels per line (>=2)
IMG_HEIGHT, 32, lines per frame (>=1); IMG_WIDTH*IMG_HEIGHT <= 2048
BASE_ADRS, 1024, word address of pixel (0,0); 11 bits
RD_LATENCY, 1, cycles from picture_radrs driven to picture_data valid (>=1)
BUF_DEPTH, RD_LATENCY+2, skid-buffer entries

Ports:
clk  input  1  picture clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a frame when idle
continuous  input  1  sampled at end of frame; 1 = restart immediately
picture_radrs  output  11  registered read address to memory picture port
picture_data  input  24  read data, valid RD_LATENCY cycles after address
pix_data  output  24  pixel at buffer head
pix_valid  output  1  pixel available
pix_ready  input  1  sink accepts; transfer = pix_valid & pix_ready
pix_sof  output  1  qualifies pix_data: pixel (0,0)
pix_eol  output  1  qualifies pix_data: last pixel of a line
pix_eof  output  1  qualifies pix_data: last pixel of frame
busy  output  1  high from the cycle after start to the end of frame
frame_done  output  1  one-cycle pulse after final transfer

Behaviour:
- Synchronous, active-high reset. While rst=1 and on the cycle after:
  - state=IDLE; picture_radrs=BASE_ADRS.
  - pix_valid, pix_sof, pix_eol, pix_eof, busy and frame_done are 0; pix_data=0.
  - Buffer, in-flight pipeline, and x/y counters cleared.
- rst asserted mid-frame abandons the frame: no frame_done, and in-flight returns are discarded.
- States:
  - IDLE: start=1 -> SCAN; x=0, y=0, picture_radrs=BASE_ADRS.
  - SCAN: reads are issued. After the read of pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is issued -> DRAIN.
  - DRAIN: no reads. On the final transfer (pix_eof & pix_valid & pix_ready) -> DONE.
  - DONE: one cycle; frame_done=1. continuous=1 -> SCAN with counters and address reset; otherwise -> IDLE.
  - busy=1 in SCAN and DRAIN, 0 in IDLE and DONE.
  - start is ignored outside IDLE.
- Read issue rule:
  - A read issues in a SCAN cycle iff (in-flight reads + buffer occupancy) < BUF_DEPTH.
  - An issued read holds its address on picture_radrs that cycle. The address then advances by 1, modulo 2^11 (wraps 2047 -> 0).
  - When no read issues, picture_radrs holds its value.
- Tag pipeline:
  - A RD_LATENCY-deep shift register carries {valid, sof, eol, eof} alongside each read.
  - The entry is written into the buffer with picture_data on the cycle the data is valid.
  - The credit rule guarantees the buffer never overflows.
- x/y counters:
  - x increments per issued read and wraps at IMG_WIDTH-1, which increments y.
  - sof is set when x=0,y=0.
  - eol is set when x=IMG_WIDTH-1.
  - eof is set when x=IMG_WIDTH-1,y=IMG_HEIGHT-1; eof implies eol.
- Output:
  - Buffer is first-word-fall-through. pix_valid = buffer not empty.
  - pix_data and the marker flags come from the head entry.
  - While pix_valid & !pix_ready, all pix_* outputs hold stable.
  - A simultaneous buffer write and transfer keeps occupancy unchanged.
- Latency and throughput:
  - With start in cycle n, the first pix_valid is at cycle n+2+RD_LATENCY.
  - With pix_ready held at 1, one pixel transfers per cycle sustained; no bubbles within a frame.
  - Continuous mode adds exactly RD_LATENCY+2 idle output cycles between frames (the DONE cycle plus the refill).
- Backpressure:
  - With pix_ready=0, at most BUF_DEPTH reads are outstanding or buffered, then issue stops.
  - Issue resumes the cycle after the first transfer frees a credit.
  - No pixel is dropped or duplicated.

Test Plan:
- Reset: assert rst 3 cycles mid-SCAN -> next cycle picture_radrs=1024, pix_valid=busy=frame_done=0; no pix_valid for 10 cycles without start.
- Single frame, pix_ready=1: start at cycle 0 -> first pix_valid at cycle 3 with pix_sof=1 (data from address 1024). Then 1024 consecutive transfers with pix_data equal to the preloaded address pattern, pix_eol on every 32nd, pix_eof on the 1024th. frame_done pulses once, then busy=0.
- Backpressure: hold pix_ready=0 for 20 cycles after the first pix_valid -> picture_radrs stops advancing after 3 buffered reads. On release, the pixel sequence is continuous with no loss or duplicate. Random 50% ready over a full frame -> a scoreboard matches all 1024 pixels.
- Continuous mode: continuous=1, pix_ready=1 -> second frame's pix_sof appears exactly 3 output cycles after the first frame's final transfer; frame_done pulses once per frame.
- start during busy: pulse start at pixel 100 -> ignored; exactly one frame and one frame_done.
- Wrap: BASE_ADRS=2040, IMG_WIDTH=4, IMG_HEIGHT=4 -> addresses 2040..2047 then 0..7; eol on pixels 3, 7, 11, 15; eof on 15.
